// File: rtl/regfile_mp.sv
// Multi-port integer register file: NUM_RD read ports, two prioritised write ports and a
// per-register busy scoreboard. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_mp #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       wen0,
    input  logic [ADDR_W-1:0]          waddr0,
    input  logic [DATA_W-1:0]          wdata0,
    input  logic                       wen1,
    input  logic [ADDR_W-1:0]          waddr1,
    input  logic [DATA_W-1:0]          wdata1,
    input  logic                       iss_en,
    input  logic [ADDR_W-1:0]          iss_rd,
    output logic [ADDR_W:0]            busy_cnt
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [Depth];
    logic [DATA_W-1:0] regs_d [Depth];
    logic [Depth-1:0]  busy_q, busy_d;
    logic [Depth-1:0]  hit0, hit1;
    logic [ADDR_W:0]   busy_cnt_q, busy_cnt_d;

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_REG != 0) && (a == '0);
    endfunction

    // Per-register write decode; the hardwired zero register never matches.
    always_comb begin
        hit0 = '0;
        hit1 = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            hit0[i] = wen0 && (waddr0 == ADDR_W'(i)) && !is_zero(ADDR_W'(i));
            hit1[i] = wen1 && (waddr1 == ADDR_W'(i)) && !is_zero(ADDR_W'(i));
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < Depth; i++) begin
            regs_d[i] = regs_q[i];
            if (hit1[i]) begin
                regs_d[i] = wdata1;
            end else if (hit0[i]) begin
                regs_d[i] = wdata0;
            end
        end
    end

    // A new issue outranks a same-cycle write: the newer producer still owns the register.
    always_comb begin
        busy_d     = busy_q;
        busy_cnt_d = '0;
        for (int unsigned i = 0; i < Depth; i++) begin
            if (iss_en && (iss_rd == ADDR_W'(i)) && !is_zero(ADDR_W'(i))) begin
                busy_d[i] = 1'b1;
            end else if (hit0[i] || hit1[i]) begin
                busy_d[i] = 1'b0;
            end
            busy_cnt_d = busy_cnt_d + (ADDR_W + 1)'(busy_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_q[i] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < Depth; i++) begin
                regs_q[i] <= regs_d[i];
            end
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Reads are gated during reset so a forwarded write cannot leak out.
    always_comb begin
        logic [ADDR_W-1:0] ra;
        ra      = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            ra = rd_addr[k*ADDR_W +: ADDR_W];
            if (!rst && !is_zero(ra)) begin
                rd_data[k*DATA_W +: DATA_W] = regs_q[ra];
                rd_busy[k]                  = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
                if (wen1 && (waddr1 == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wdata1;
                    rd_busy[k]                  = 1'b0;
                end else if (wen0 && (waddr0 == ra)) begin
                    rd_data[k*DATA_W +: DATA_W] = wdata0;
                    rd_busy[k]                  = 1'b0;
                end
`else
`endif
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule
